// File: rtl/neuron_train_sequencer.sv
// Training-data sequencer: stores labelled samples and replays them to the neuron
// over the request/data_ready handshake, epoch after epoch, until done or timeout.
module neuron_train_sequencer #(
    parameter int DEPTH      = 512,
    parameter int AW         = 9,
    parameter int MAX_EPOCHS = 1024
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [6:0]    wr_x1,
    input  logic [6:0]    wr_x2,
    input  logic [1:0]    wr_t,
    input  logic [AW:0]   n_samples,
    input  logic          go,
    output logic          n_start,
    output logic [31:0]   n_count,
    output logic [6:0]    x1,
    output logic [6:0]    x2,
    output logic [1:0]    t,
    output logic          data_ready,
    input  logic          request,
    input  logic          neuron_done,
    output logic          busy,
    output logic          finished,
    output logic          timeout,
    output logic          error,
    output logic [15:0]   epoch,
    output logic [AW-1:0] sample_idx
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_FETCH,
        S_LOAD,
        S_WAIT_REQ,
        S_PRESENT,
        S_GAP
    } state_t;

    state_t      state_reg;
    logic        start_cnt_reg;
    logic [AW:0] n_last_reg;
    logic [15:0] ram_q_reg;
    logic [15:0] epoch_next;
    logic        wr_ok;
    logic        rd_en;
    logic        last_sample;

    // Sample store: contents are never reset, so it lives outside the reset domain.
    logic [15:0] mem [DEPTH];

    always_comb begin
        wr_ok       = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
        rd_en       = (state_reg == S_FETCH);
        last_sample = ({1'b0, sample_idx} == n_last_reg);
        epoch_next  = (epoch == 16'hFFFF) ? epoch : epoch + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[IW-1:0]] <= {wr_x1, wr_x2, wr_t};
        end
        if (rd_en) begin
            ram_q_reg <= mem[sample_idx[IW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            start_cnt_reg <= 1'b0;
            n_last_reg    <= '0;
            n_start       <= 1'b0;
            n_count       <= '0;
            x1            <= '0;
            x2            <= '0;
            t             <= '0;
            data_ready    <= 1'b0;
            busy          <= 1'b0;
            finished      <= 1'b0;
            timeout       <= 1'b0;
            error         <= 1'b0;
            epoch         <= '0;
            sample_idx    <= '0;
        end else if (state_reg != S_IDLE && neuron_done) begin
            // Convergence overrides everything; index and epoch stay where they were.
            state_reg  <= S_IDLE;
            finished   <= 1'b1;
            data_ready <= 1'b0;
            n_start    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (go) begin
                        if (n_samples == '0 || n_samples > DEPTH_W) begin
                            error <= 1'b1;
                        end else begin
                            n_last_reg    <= n_samples - (AW+1)'(1);
                            n_count       <= 32'(n_samples);
                            finished      <= 1'b0;
                            timeout       <= 1'b0;
                            error         <= 1'b0;
                            epoch         <= '0;
                            sample_idx    <= '0;
                            start_cnt_reg <= 1'b0;
                            n_start       <= 1'b1;
                            busy          <= 1'b1;
                            state_reg     <= S_START;
                        end
                    end
                end
                S_START: begin
                    if (start_cnt_reg) begin
                        n_start   <= 1'b0;
                        state_reg <= S_FETCH;
                    end else begin
                        start_cnt_reg <= 1'b1;
                    end
                end
                S_FETCH: begin
                    state_reg <= S_LOAD;
                end
                S_LOAD: begin
                    {x1, x2, t} <= ram_q_reg;
                    state_reg   <= S_WAIT_REQ;
                end
                S_WAIT_REQ: begin
                    if (request) begin
                        data_ready <= 1'b1;
                        state_reg  <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (!request) begin
                        data_ready <= 1'b0;
                        state_reg  <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (last_sample) begin
                        sample_idx <= '0;
                        epoch      <= epoch_next;
                        if (32'(epoch_next) == 32'(MAX_EPOCHS)) begin
                            timeout   <= 1'b1;
                            busy      <= 1'b0;
                            state_reg <= S_IDLE;
                        end else begin
                            state_reg <= S_FETCH;
                        end
                    end else begin
                        sample_idx <= sample_idx + AW'(1);
                        state_reg  <= S_FETCH;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_train_sequencer.sv
// Scenario bench for neuron_train_sequencer: a small neuron model drives the handshake
// and a queue of expected {sample_idx, x1, x2, t} is checked at every presentation.
module tb_neuron_train_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0, wr_en_b = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [6:0]    wr_x1 = '0, wr_x2 = '0;
    logic [1:0]    wr_t = '0;
    logic [AW:0]   n_samples = '0;
    logic          go = 1'b0, go_b = 1'b0;
    logic          request = 1'b0, request_b = 1'b0;
    logic          neuron_done = 1'b0, neuron_done_b = 1'b0;

    logic          n_start, n_start_b;
    logic [31:0]   n_count, n_count_b;
    logic [6:0]    x1, x2, x1_b, x2_b;
    logic [1:0]    t, t_b;
    logic          data_ready, data_ready_b;
    logic          busy, busy_b, finished, finished_b;
    logic          timeout, timeout_b, error, error_b;
    logic [15:0]   epoch, epoch_b;
    logic [AW-1:0] sample_idx, sample_idx_b;

    neuron_train_sequencer #(.DEPTH(DEPTH), .AW(AW), .MAX_EPOCHS(1024)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_x1(wr_x1),
        .wr_x2(wr_x2), .wr_t(wr_t), .n_samples(n_samples), .go(go),
        .n_start(n_start), .n_count(n_count), .x1(x1), .x2(x2), .t(t),
        .data_ready(data_ready), .request(request), .neuron_done(neuron_done),
        .busy(busy), .finished(finished), .timeout(timeout), .error(error),
        .epoch(epoch), .sample_idx(sample_idx)
    );

    neuron_train_sequencer #(.DEPTH(DEPTH), .AW(AW), .MAX_EPOCHS(2)) u_dut_to (
        .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_x1(wr_x1),
        .wr_x2(wr_x2), .wr_t(wr_t), .n_samples(n_samples), .go(go_b),
        .n_start(n_start_b), .n_count(n_count_b), .x1(x1_b), .x2(x2_b), .t(t_b),
        .data_ready(data_ready_b), .request(request_b), .neuron_done(neuron_done_b),
        .busy(busy_b), .finished(finished_b), .timeout(timeout_b), .error(error_b),
        .epoch(epoch_b), .sample_idx(sample_idx_b)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [19:0] exp_q[$];
    bit sel = 1'b0;

    int sx1[4] = '{3, -5, 7, -1};
    int sx2[4] = '{-2, 4, 7, -6};
    int st[4]  = '{1, -1, 1, -1};

    wire [73:0] all_a = {n_start, n_count, x1, x2, t, data_ready, busy, finished,
                         timeout, error, epoch, sample_idx};
    wire [73:0] all_b = {n_start_b, n_count_b, x1_b, x2_b, t_b, data_ready_b, busy_b,
                         finished_b, timeout_b, error_b, epoch_b, sample_idx_b};
    wire        obs_dr = sel ? data_ready_b : data_ready;
    wire [19:0] obs_sample = sel ? {sample_idx_b, x1_b, x2_b, t_b} : {sample_idx, x1, x2, t};

    function automatic logic [15:0] sample_bits(input int i);
        return {7'(sx1[i]), 7'(sx2[i]), 2'(st[i])};
    endfunction

    task automatic push_expected(input int i);
        exp_q.push_back({4'(i), sample_bits(i)});
    endtask

    task automatic load_samples();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_en_b = 1'b1; wr_addr = AW'(i);
            wr_x1 = 7'(sx1[i]); wr_x2 = 7'(sx2[i]); wr_t = 2'(st[i]);
        end
        @(negedge clk);
        wr_en = 1'b0; wr_en_b = 1'b0;
    endtask

    // Returns at the negedge of the cycle right after the accepting edge.
    task automatic pulse_go(input bit b, input int n);
        n_samples = (AW+1)'(n);
        if (b) go_b = 1'b1; else go = 1'b1;
        @(negedge clk);
        go = 1'b0; go_b = 1'b0;
    endtask

    // One handshake: raise request, wait for data_ready, check the sample, drop request.
    task automatic present_one(input bit b);
        bit seen;
        logic [19:0] expv;
        sel = b;
        if (b) request_b = 1'b1; else request = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (obs_dr) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL present_wait: data_ready got 0 required 1 within 40 cycles");
        end else begin
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : 20'hxxxxx;
            if (obs_sample !== expv) begin
                miscompares++;
                $display("FAIL present_sample: got %h required %h", obs_sample, expv);
            end
        end
        if (b) request_b = 1'b0; else request = 1'b0;
        @(negedge clk);
        vectors++;
        if (obs_dr !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_data_ready: got %b required 0", obs_dr);
        end
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if (all_a !== '0 || all_b !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h/%h required 0", all_a, all_b);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (all_a !== '0) begin
            miscompares++;
            $display("FAIL reset_release: got %h required 0", all_a);
        end
    endtask

    task automatic test_error_zero();
        pulse_go(1'b0, 0);
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL error_zero: error/busy got %b%b required 10", error, busy);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (n_start !== 1'b0 || busy !== 1'b0) begin
                miscompares++;
                $display("FAIL error_zero_idle: n_start/busy got %b%b required 00", n_start, busy);
            end
        end
    endtask

    task automatic test_train();
        load_samples();
        for (int i = 0; i < 10; i++) push_expected(i % 4);
        pulse_go(1'b0, 4);
        vectors++;
        if (busy !== 1'b1 || n_start !== 1'b1 || error !== 1'b0 || n_count !== 32'd4) begin
            miscompares++;
            $display("FAIL go_k1: busy/n_start/error got %b%b%b n_count %0d required 110 4",
                     busy, n_start, error, n_count);
        end
        @(negedge clk);
        vectors++;
        if (n_start !== 1'b1) begin
            miscompares++;
            $display("FAIL go_k2: n_start got %b required 1", n_start);
        end
        @(negedge clk);
        vectors++;
        if (n_start !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL go_k3: n_start/busy got %b%b required 01", n_start, busy);
        end
        for (int i = 0; i < 10; i++) begin
            present_one(1'b0);
            if (i == 0) begin
                // Overwrite attempt while busy; must not reach the store.
                wr_en = 1'b1; wr_addr = '0; wr_x1 = '0; wr_x2 = '0; wr_t = '0;
                @(negedge clk);
                wr_en = 1'b0;
            end
            if (i == 2) begin
                n_samples = '0; go = 1'b1;
                @(negedge clk);
                go = 1'b0; n_samples = (AW+1)'(4);
            end
        end
        @(negedge clk);
        neuron_done = 1'b1;
        @(negedge clk);
        neuron_done = 1'b0;
        vectors++;
        if (busy !== 1'b0 || finished !== 1'b1 || timeout !== 1'b0 || data_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL train_done: busy/finished/timeout/dr got %b%b%b%b required 0100",
                     busy, finished, timeout, data_ready);
        end
        vectors++;
        if (epoch !== 16'd2 || sample_idx !== AW'(2)) begin
            miscompares++;
            $display("FAIL train_pos: epoch %0d idx %0d required 2 2", epoch, sample_idx);
        end
        vectors++;
        if (error !== 1'b0 || n_count !== 32'd4 || exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL train_ignored_go: error %b n_count %0d left %0d required 0 4 0",
                     error, n_count, exp_q.size());
        end
    endtask

    task automatic test_done_in_wait();
        request = 1'b1;
        pulse_go(1'b0, 4);
        repeat (4) @(negedge clk);
        vectors++;
        if ({x1, x2, t} !== sample_bits(0) || data_ready !== 1'b0 || busy !== 1'b1 ||
            finished !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_k5: sample %h dr %b busy %b fin %b required %h 0 1 0",
                     {x1, x2, t}, data_ready, busy, finished, sample_bits(0));
        end
        neuron_done = 1'b1;
        @(negedge clk);
        neuron_done = 1'b0;
        vectors++;
        if (data_ready !== 1'b0 || busy !== 1'b0 || finished !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_done: dr/busy/finished got %b%b%b required 001",
                     data_ready, busy, finished);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vectors++;
            if (data_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL wait_no_pulse: data_ready got 1 required 0");
            end
        end
        request = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        request = 1'b1;
        pulse_go(1'b0, 4);
        seen = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (data_ready) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            miscompares++;
            $display("FAIL reset_mid_reach: data_ready got 0 required 1");
        end
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (data_ready !== 1'b0 || n_start !== 1'b0 || all_a !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_async: outputs got %h required 0", all_a);
        end
        request = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (all_a !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_after: outputs got %h required 0", all_a);
        end
        push_expected(0);
        pulse_go(1'b0, 4);
        present_one(1'b0);
        @(negedge clk);
        neuron_done = 1'b1;
        @(negedge clk);
        neuron_done = 1'b0;
        vectors++;
        if (finished !== 1'b1 || busy !== 1'b0 || sample_idx !== AW'(1)) begin
            miscompares++;
            $display("FAIL reset_mid_restart: fin/busy %b%b idx %0d required 10 1",
                     finished, busy, sample_idx);
        end
    endtask

    task automatic test_error_big();
        pulse_go(1'b0, DEPTH + 1);
        vectors++;
        if (error !== 1'b1 || busy !== 1'b0 || n_start !== 1'b0 || n_count !== 32'd4) begin
            miscompares++;
            $display("FAIL error_big: error/busy/n_start %b%b%b n_count %0d required 100 4",
                     error, busy, n_start, n_count);
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 6; i++) push_expected(i % 3);
        pulse_go(1'b1, 3);
        for (int i = 0; i < 6; i++) present_one(1'b1);
        vectors++;
        if (timeout_b !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: timeout got 1 required 0");
        end
        @(negedge clk);
        vectors++;
        if (timeout_b !== 1'b1 || busy_b !== 1'b0 || finished_b !== 1'b0 || epoch_b !== 16'd2) begin
            miscompares++;
            $display("FAIL timeout_end: to/busy/fin %b%b%b epoch %0d required 100 2",
                     timeout_b, busy_b, finished_b, epoch_b);
        end
        request_b = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (data_ready_b !== 1'b0) begin
                miscompares++;
                $display("FAIL timeout_extra: data_ready got 1 required 0");
            end
        end
        request_b = 1'b0;
    endtask

    initial begin
        test_reset();
        test_error_zero();
        test_train();
        test_done_in_wait();
        test_reset_mid();
        test_error_big();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/neuron_train_sequencer.md
# neuron_train_sequencer

Training-data sequencer that sits between a sample store and the `Neuron` training datapath. It holds up to `DEPTH` labelled samples (x1, x2, t) loaded by the host. On `go` it starts the neuron and answers each `request` with the next sample over the request/data-ready handshake. It wraps around the sample set in epochs until the neuron reports `done` or an epoch limit is hit.

## Interface

Parameters:
- `DEPTH`, 512: sample store entries.
- `AW`, 9: address width; `DEPTH <= 2**AW`.
- `MAX_EPOCHS`, 1024: epoch limit before timeout, ≥1.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous and active-low.
- `wr_en` in 1: sample store write strobe.
- `wr_addr` in AW: write address.
- `wr_x1`, `wr_x2` in 7 each: signed features to store.
- `wr_t` in 2: signed target to store.
- `n_samples` in AW+1: number of valid entries, 0..DEPTH; sampled on `go`.
- `go` in 1: start training; single-cycle pulse.
- `n_start` out 1: neuron start.
- `n_count` out 32: sample count to neuron; zero-extended `n_samples`.
- `x1`, `x2` out 7 each: signed sample presented to the neuron.
- `t` out 2: signed target presented to the neuron.
- `data_ready` out 1: presented sample valid.
- `request` in 1: neuron requests a sample.
- `neuron_done` in 1: neuron training converged.
- `busy` out 1: training sequence active.
- `finished` out 1: sticky; neuron reported done.
- `timeout` out 1: sticky; `MAX_EPOCHS` exhausted.
- `error` out 1: sticky; `go` with `n_samples` = 0 or `n_samples` > DEPTH.
- `epoch` out 16: completed epochs.
- `sample_idx` out AW: index of the current or next sample.

## Operation

Sample store:
- `DEPTH` × 16-bit synchronous RAM; no reset of contents.
- Writes occur only while `busy`=0. `wr_en` while `busy`=1 is ignored.
- Reads are synchronous with one-cycle latency.

States:
- IDLE: `busy`=0. On `go`:
  - If `n_samples` = 0 or `n_samples` > DEPTH: set `error`, stay in IDLE.
  - Otherwise: latch `n_samples`, clear `finished`/`timeout`/`error`/`epoch`/`sample_idx`, go to START.
- START: `n_start`=1 for exactly 2 cycles, then go to FETCH.
- FETCH: issue RAM read at `sample_idx`, then go to LOAD.
- LOAD: register RAM data onto `x1`/`x2`/`t`, then go to WAIT_REQ.
- WAIT_REQ: `data_ready`=0. Go to PRESENT when `request`=1.
- PRESENT: `data_ready`=1. Stay while `request`=1. When `request`=0 go to GAP.
- GAP: `data_ready`=0 for one cycle, then advance:
  - If `sample_idx` = n−1: `sample_idx`←0 and `epoch`←`epoch`+1.
    - If the new `epoch` = MAX_EPOCHS: set `timeout`, go to IDLE.
    - Otherwise go to FETCH.
  - Otherwise: `sample_idx`+1, go to FETCH.

Priority and ignored inputs:
- `neuron_done`=1 in any state except IDLE has highest priority. Next state is IDLE, `finished`=1, `data_ready`=0, and `sample_idx`/`epoch` are frozen.
- `go` while `busy`=1 is ignored.
- `request` outside WAIT_REQ/PRESENT is ignored. It is acted on once WAIT_REQ is reached.

Hold rules:
- `x1`/`x2`/`t` hold stable from LOAD until the next LOAD.
- `n_count` holds from `go` until the next accepted `go`.

Arithmetic:
- `epoch` saturates at 16'hFFFF.
- `sample_idx` compares against the latched n−1 (AW+1-bit compare).

## Timing

- Reset (`rst`=0), applied asynchronously: state IDLE. Every output is 0: `n_start`, `n_count`, `x1`, `x2`, `t`, `data_ready`, `busy`, `finished`, `timeout`, `error`, `epoch`, `sample_idx`.
- Reset mid-operation: `data_ready` and `n_start` drop without waiting for a clock.
- `go` accepted at edge k:
  - `busy`=1 and `n_start`=1 for cycles k+1 and k+2.
  - FETCH at k+3.
  - Sample valid on `x1`/`x2`/`t` at k+5 (WAIT_REQ).
- `request` high during WAIT_REQ: `data_ready`=1 in the next cycle.
- `request` falls: `data_ready`=0 in the next cycle (GAP).
- Minimum period per sample is 5 cycles: GAP, FETCH, LOAD, WAIT_REQ, PRESENT.
- `neuron_done` sampled at edge k: `busy`=0 and `finished`=1 from k+1.

## Test plan

- Load 4 samples {(3,−2,1),(−5,4,−1),(7,7,1),(−1,−6,−1)}, `n_samples`=4, `go`. The neuron model requests continuously and asserts `done` after 10 presentations. Required: samples presented in order 0,1,2,3,0,…; `epoch`=2 and `sample_idx`=2 at done; `finished`=1; `busy`=0.
- `go` with `n_samples`=0 → `error`=1 next cycle; `n_start` never asserted; `busy` stays 0.
- `MAX_EPOCHS`=2, `n_samples`=3, `neuron_done` never asserted → `timeout`=1 after exactly 6 presentations; `finished`=0; `epoch`=2.
- Assert `rst`=0 while in PRESENT → `data_ready`=0 immediately. After release, all outputs are 0; a following `go` restarts at sample 0.
- During training, write sample 0 with (0,0,0) → ignored; the epoch-1 presentation of sample 0 still shows (3,−2,1).
- `neuron_done` while in WAIT_REQ with `request`=1 → no `data_ready` pulse; IDLE next cycle; `finished`=1.
